// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-client arbiter onto one memory put/get port pair,
// with a tag FIFO routing each response back to its issuing client in order.
module mem_arbiter #(
  parameter int OP_WIDTH  = 68,
  parameter int TAG_DEPTH = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 c0_req_valid,
  input  logic [OP_WIDTH-1:0]  c0_req_data,
  output logic                 c0_req_ready,
  input  logic                 c1_req_valid,
  input  logic [OP_WIDTH-1:0]  c1_req_data,
  output logic                 c1_req_ready,
  output logic                 c0_resp_valid,
  input  logic                 c0_resp_ready,
  output logic                 c1_resp_valid,
  input  logic                 c1_resp_ready,
  output logic [OP_WIDTH-1:0]  resp_data,
  output logic                 mem_put_enable,
  input  logic                 mem_put_ready,
  output logic [OP_WIDTH-1:0]  mem_put_request,
  output logic                 mem_get_enable,
  input  logic                 mem_get_ready,
  input  logic [OP_WIDTH-1:0]  mem_get_response,
  output logic [CNT_WIDTH-1:0] c0_grant_cnt,
  output logic [CNT_WIDTH-1:0] c1_grant_cnt
);
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int PW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
  logic [TAG_DEPTH-1:0] tags;
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic                 last_grant, sel, issue, head, pop;
  // Outputs are gated by RST_N so everything reads 0 while reset is held.
  always_comb begin
    sel = c0_req_valid & c1_req_valid ? ~last_grant : c1_req_valid;
    issue = RST_N & (c0_req_valid | c1_req_valid) & mem_put_ready & (count < CW'(TAG_DEPTH));
    head = tags[rd_ptr];
    c0_req_ready = issue & ~sel;
    c1_req_ready = issue & sel;
    mem_put_enable = issue;
    mem_put_request = issue ? (sel ? c1_req_data : c0_req_data) : '0;
    c0_resp_valid = RST_N & mem_get_ready & (count != '0) & ~head;
    c1_resp_valid = RST_N & mem_get_ready & (count != '0) & head;
    pop = (c0_resp_valid & c0_resp_ready) | (c1_resp_valid & c1_resp_ready);
    mem_get_enable = pop;
    resp_data = RST_N ? mem_get_response : '0;
  end
  // Push is gated on the pre-pop count: a full FIFO never takes a same-cycle bypass.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      tags <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      last_grant <= 1'b1;
      c0_grant_cnt <= '0;
      c1_grant_cnt <= '0;
    end else begin
      if (issue) begin
        tags[wr_ptr] <= sel;
        wr_ptr <= wr_ptr == PW'(TAG_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        last_grant <= sel;
      end
      if (pop) rd_ptr <= rd_ptr == PW'(TAG_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(issue) - CW'(pop);
      c0_grant_cnt <= c0_grant_cnt + CNT_WIDTH'(c0_req_ready);
      c1_grant_cnt <= c1_grant_cnt + CNT_WIDTH'(c1_req_ready);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus randomized traffic against an in-order
// list model of outstanding tags and a simple one-cycle-turnaround memory.
module tb_mem_arbiter;
  localparam int W = 68, D = 2, CW = 4;
  logic CLK = 0, RST_N = 0;
  logic c0v = 0, c1v = 0, rr0 = 0, rr1 = 0, put_allow = 0, get_allow = 0;
  logic [W-1:0] c0d = '0, c1d = '0;
  logic c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid;
  logic mem_put_enable, mem_get_enable, mem_get_ready;
  logic [W-1:0] resp_data, mem_put_request, mem_get_response;
  logic [CW-1:0] c0_grant_cnt, c1_grant_cnt;
  int n_pass = 0, n_total = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.OP_WIDTH(W), .TAG_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .c0_req_valid(c0v), .c0_req_data(c0d), .c0_req_ready(c0_req_ready),
    .c1_req_valid(c1v), .c1_req_data(c1d), .c1_req_ready(c1_req_ready),
    .c0_resp_valid(c0_resp_valid), .c0_resp_ready(rr0),
    .c1_resp_valid(c1_resp_valid), .c1_resp_ready(rr1),
    .resp_data(resp_data),
    .mem_put_enable(mem_put_enable), .mem_put_ready(put_allow), .mem_put_request(mem_put_request),
    .mem_get_enable(mem_get_enable), .mem_get_ready(mem_get_ready), .mem_get_response(mem_get_response),
    .c0_grant_cnt(c0_grant_cnt), .c1_grant_cnt(c1_grant_cnt)
  );

  // Memory: accepted requests come back one cycle later, addr echoed, data = ~addr.
  logic [W-1:0] mem_a [0:15];
  int mem_rd = 0, mem_wr = 0, mem_n;
  assign mem_n = mem_wr - mem_rd;
  assign mem_get_ready = get_allow && mem_n > 0;
  assign mem_get_response = mem_a[mem_rd % 16];

  // Reference model: outstanding tags as an ordered list, head at bit 0.
  logic m_lg = 1;
  logic [15:0] m_tags = '0, e_tags;
  int m_n = 0, m_c0 = 0, m_c1 = 0, e_n;
  logic e_sel, e_issue, e_rv0, e_rv1, e_pop;
  always @* begin
    e_sel = (c0v && c1v) ? !m_lg : c1v;
    e_issue = RST_N && (c0v || c1v) && put_allow && m_n < D;
    e_rv0 = RST_N && mem_get_ready && m_n > 0 && !m_tags[0];
    e_rv1 = RST_N && mem_get_ready && m_n > 0 && m_tags[0];
    e_pop = (e_rv0 && rr0) || (e_rv1 && rr1);
    e_tags = e_pop ? m_tags >> 1 : m_tags;
    e_n = m_n - (e_pop ? 1 : 0);
    if (e_issue) begin
      e_tags[e_n] = e_sel;
      e_n = e_n + 1;
    end
  end

  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      m_lg <= 1; m_n <= 0; m_tags <= '0; m_c0 <= 0; m_c1 <= 0; mem_rd <= 0; mem_wr <= 0;
    end else begin
      if (mem_put_enable) begin
        mem_a[mem_wr % 16] <= {mem_put_request[67:32], ~mem_put_request[63:32]};
        mem_wr <= mem_wr + 1;
      end
      if (mem_get_enable) mem_rd <= mem_rd + 1;
      if (e_issue) begin
        m_lg <= e_sel;
        if (e_sel) m_c1 <= m_c1 + 1; else m_c0 <= m_c0 + 1;
      end
      m_tags <= e_tags;
      m_n <= e_n;
    end

  logic [5:0] obs, exp_v;
  logic [W-1:0] exp_req;
  assign obs = {c0_req_ready, c1_req_ready, mem_put_enable, c0_resp_valid, c1_resp_valid, mem_get_enable};
  assign exp_v = {e_issue && !e_sel, e_issue && e_sel, e_issue, e_rv0, e_rv1, e_pop};
  assign exp_req = e_sel ? c1d : c0d;

  function automatic logic [W-1:0] mk(input logic c, input logic [31:0] a);
    return {4'hF, c, a[30:0], 32'($urandom)};
  endfunction

  task automatic do_reset;
    RST_N = 0;
    @(negedge CLK);
    RST_N = 1;
  endtask

  task automatic drain;
    c0v = 0; c1v = 0; rr0 = 1; rr1 = 1; get_allow = 1;
    for (int i = 0; i < 20 && m_n != 0; i++) begin
      #1;
      n_total++; if (obs !== exp_v) $display("FAIL drain cyc %0d: outputs %b, want %b", i, obs, exp_v); else n_pass++;
      @(negedge CLK);
    end
    n_total++; if (m_n != 0) $display("FAIL drain_timeout: %0d tags left, want 0", m_n); else n_pass++;
  endtask

  task automatic test_reset;
    RST_N = 0; c0v = 1; c1v = 1; put_allow = 1; get_allow = 1; rr0 = 1; rr1 = 1;
    c0d = mk(0, 32'h40); c1d = mk(1, 32'h80);
    repeat (3) begin
      @(negedge CLK); #1;
      n_total++;
      if ({obs, c0_grant_cnt, c1_grant_cnt, mem_put_request, resp_data} !== '0)
        $display("FAIL reset_outputs: obs=%b cnt0=%0d cnt1=%0d req=%h resp=%h, want all 0",
                 obs, c0_grant_cnt, c1_grant_cnt, mem_put_request, resp_data);
      else n_pass++;
    end
    @(negedge CLK); RST_N = 1; #1;
    n_total++; if ({c0_req_ready, c1_req_ready} !== 2'b10) $display("FAIL reset_first_grant: ready %b, want 10", {c0_req_ready, c1_req_ready}); else n_pass++;
    @(negedge CLK); #1;
    n_total++; if (c0_grant_cnt !== 4'd1 || c1_grant_cnt !== 4'd0) $display("FAIL reset_first_cnt: cnt0=%0d cnt1=%0d, want 1 0", c0_grant_cnt, c1_grant_cnt); else n_pass++;
    drain;
  endtask

  task automatic test_contention;
    int k;
    logic [31:0] q[$];
    do_reset;
    c0v = 1; c1v = 1; put_allow = 1; get_allow = 1; rr0 = 1; rr1 = 1; k = 0;
    for (int i = 0; i < 40 && k < 8; i++) begin
      c0d = mk(0, $urandom & ~32'h3); c1d = mk(1, $urandom & ~32'h3); #1;
      n_total++; if (obs !== exp_v) $display("FAIL contention cyc %0d: outputs %b, want %b", i, obs, exp_v); else n_pass++;
      if (mem_get_enable) begin
        n_total++;
        if (q.size() == 0 || resp_data[63:32] !== q[0] || resp_data[63] !== c1_resp_valid)
          $display("FAIL contention_route: addr %h to c1=%b, want addr %h", resp_data[63:32], c1_resp_valid, q.size() ? q[0] : 32'hx);
        else n_pass++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (mem_put_enable) begin
        n_total++;
        if (c1_req_ready !== (k % 2 == 1) || mem_put_request !== exp_req)
          $display("FAIL contention_order issue %0d: client %b req %h, want client %0d req %h", k, c1_req_ready, mem_put_request, k % 2, exp_req);
        else n_pass++;
        q.push_back(mem_put_request[63:32]);
        k++;
      end
      @(negedge CLK);
    end
    n_total++; if (k != 8) $display("FAIL contention_issues: %0d issues, want 8", k); else n_pass++;
    drain;
    n_total++; if (c0_grant_cnt !== 4'd4 || c1_grant_cnt !== 4'd4) $display("FAIL contention_cnt: %0d %0d, want 4 4", c0_grant_cnt, c1_grant_cnt); else n_pass++;
  endtask

  task automatic test_lone;
    int k, r;
    c0v = 0; rr0 = 1; rr1 = 1; get_allow = 1; put_allow = 1; k = 0; r = 0;
    for (int i = 0; i < 12; i++) begin
      c1v = k < 5; c1d = mk(1, 32'h100 + 4 * k); #1;
      n_total++; if (obs !== exp_v) $display("FAIL lone cyc %0d: outputs %b, want %b", i, obs, exp_v); else n_pass++;
      if (i < 5) begin
        n_total++; if (c1_req_ready !== 1'b1) $display("FAIL lone_no_idle cyc %0d: c1_req_ready %b, want 1", i, c1_req_ready); else n_pass++;
      end
      n_total++; if (c0_resp_valid !== 1'b0) $display("FAIL lone_c0_quiet cyc %0d: c0_resp_valid %b, want 0", i, c0_resp_valid); else n_pass++;
      if (mem_get_enable) begin
        n_total++; if (resp_data[63:32] !== 32'h8000_0100 + 4 * r) $display("FAIL lone_addr %0d: %h, want %h", r, resp_data[63:32], 32'h8000_0100 + 4 * r); else n_pass++;
        r++;
      end
      if (c1_req_ready) k++;
      @(negedge CLK);
    end
    n_total++; if (r != 5) $display("FAIL lone_resps: %0d responses, want 5", r); else n_pass++;
    drain;
  endtask

  task automatic test_full_fifo;
    int k;
    get_allow = 0; put_allow = 1; c0v = 1; c1v = 1; rr0 = 1; rr1 = 1; k = 0;
    for (int i = 0; i < 4; i++) begin
      c0d = mk(0, 32'h200 + 4 * i); c1d = mk(1, 32'h300 + 4 * i); #1;
      n_total++; if (obs !== exp_v) $display("FAIL full cyc %0d: outputs %b, want %b", i, obs, exp_v); else n_pass++;
      if (c0_req_ready || c1_req_ready) k++;
      @(negedge CLK);
    end
    n_total++; if (k != 2) $display("FAIL full_issues: %0d issues, want 2", k); else n_pass++;
    get_allow = 1; #1;
    n_total++; if ({mem_get_enable, c0_req_ready | c1_req_ready} !== 2'b10) $display("FAIL full_no_bypass: get,ready %b, want 10", {mem_get_enable, c0_req_ready | c1_req_ready}); else n_pass++;
    @(negedge CLK); #1;
    n_total++; if ((c0_req_ready | c1_req_ready) !== 1'b1) $display("FAIL full_reissue: ready %b, want 1", c0_req_ready | c1_req_ready); else n_pass++;
    n_total++; if (obs !== exp_v) $display("FAIL full_after_pop: outputs %b, want %b", obs, exp_v); else n_pass++;
    @(negedge CLK);
    drain;
  endtask

  task automatic test_hol;
    get_allow = 0; put_allow = 1; rr0 = 0; rr1 = 1;
    c0v = 1; c1v = 0; c0d = mk(0, 32'h400); #1;
    @(negedge CLK);
    c0v = 0; c1v = 1; c1d = mk(1, 32'h500); #1;
    @(negedge CLK);
    c1v = 0; get_allow = 1;
    repeat (3) begin
      #1;
      n_total++; if ({c0_resp_valid, c1_resp_valid, mem_get_enable} !== 3'b100) $display("FAIL hol_stall: v0,v1,get %b, want 100", {c0_resp_valid, c1_resp_valid, mem_get_enable}); else n_pass++;
      @(negedge CLK);
    end
    rr0 = 1; #1;
    n_total++; if ({c0_resp_valid, c1_resp_valid, mem_get_enable} !== 3'b101 || resp_data[63:32] !== 32'h400) $display("FAIL hol_serve0: v0,v1,get %b addr %h, want 101 addr 400", {c0_resp_valid, c1_resp_valid, mem_get_enable}, resp_data[63:32]); else n_pass++;
    @(negedge CLK); #1;
    n_total++; if ({c0_resp_valid, c1_resp_valid, mem_get_enable} !== 3'b011 || resp_data[63:32] !== 32'h8000_0500) $display("FAIL hol_serve1: v0,v1,get %b addr %h, want 011 addr 80000500", {c0_resp_valid, c1_resp_valid, mem_get_enable}, resp_data[63:32]); else n_pass++;
    @(negedge CLK);
    drain;
  endtask

  task automatic test_wrap_async;
    int k;
    do_reset;
    c0v = 1; c1v = 0; put_allow = 1; get_allow = 1; rr0 = 1; rr1 = 1; k = 0;
    for (int i = 0; i < 40 && k < 17; i++) begin
      c0d = mk(0, 32'h600 + 4 * i); #1;
      n_total++; if (obs !== exp_v) $display("FAIL wrap cyc %0d: outputs %b, want %b", i, obs, exp_v); else n_pass++;
      if (c0_req_ready) k++;
      @(negedge CLK);
    end
    c0v = 0; #1;
    n_total++; if (c0_grant_cnt !== 4'd1) $display("FAIL wrap_cnt: %0d, want 1", c0_grant_cnt); else n_pass++;
    drain;
    get_allow = 0; c0v = 1;
    repeat (2) begin
      #1; @(negedge CLK);
    end
    get_allow = 1; rr0 = 0; #1;
    n_total++; if (c0_resp_valid !== 1'b1 || c0_req_ready !== 1'b0) $display("FAIL async_pre: v0 %b ready %b, want 1 0", c0_resp_valid, c0_req_ready); else n_pass++;
    #1; RST_N = 0; #1;
    n_total++;
    if ({obs, c0_grant_cnt, c1_grant_cnt, mem_put_request, resp_data} !== '0)
      $display("FAIL async_clear: obs=%b cnt0=%0d cnt1=%0d req=%h resp=%h, want all 0", obs, c0_grant_cnt, c1_grant_cnt, mem_put_request, resp_data);
    else n_pass++;
    @(negedge CLK); RST_N = 1; #1;
    n_total++; if ({c0_req_ready, c0_resp_valid} !== 2'b10) $display("FAIL async_tags_gone: ready,v0 %b, want 10", {c0_req_ready, c0_resp_valid}); else n_pass++;
    drain;
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      c0v = 1'($urandom); c1v = 1'($urandom); rr0 = ($urandom % 4) != 0; rr1 = ($urandom % 4) != 0;
      put_allow = ($urandom % 4) != 0; get_allow = ($urandom % 3) != 0;
      c0d = mk(0, $urandom & ~32'h3); c1d = mk(1, $urandom & ~32'h3); #1;
      n_total++; if (obs !== exp_v) $display("FAIL random cyc %0d: outputs %b, want %b", i, obs, exp_v); else n_pass++;
      n_total++; if (c0_grant_cnt !== 4'(m_c0) || c1_grant_cnt !== 4'(m_c1)) $display("FAIL random_cnt cyc %0d: %0d %0d, want %0d %0d", i, c0_grant_cnt, c1_grant_cnt, 4'(m_c0), 4'(m_c1)); else n_pass++;
      if (e_issue) begin
        n_total++; if (mem_put_request !== exp_req) $display("FAIL random_req cyc %0d: %h, want %h", i, mem_put_request, exp_req); else n_pass++;
      end
      if (c0_resp_valid || c1_resp_valid) begin
        n_total++; if (resp_data[63] !== c1_resp_valid) $display("FAIL random_route cyc %0d: owner bit %b to c1=%b", i, resp_data[63], c1_resp_valid); else n_pass++;
      end
      @(negedge CLK);
    end
    drain;
  endtask

  initial begin
    test_reset;
    test_contention;
    test_lone;
    test_full_fifo;
    test_hol;
    test_wrap_async;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
